// File: rtl/lvds_rx_pkg.sv
// Shared state encoding, rPLL constants and training-word matcher
// for the LVDS RX phase tuner.
package lvds_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOCK,
        SETTLE,
        SAMPLE,
        EVAL,
        PICK,
        DONE,
        FAIL
    } state_t;

    localparam int PSDA_W = 4;
    localparam logic [3:0] DUTYDA_DEF = 4'b1000;
    localparam logic [3:0] FDLY_DEF = 4'b0000;

    // True when word equals any n-bit rotation of pat (n <= 16).
    function automatic logic is_rotation(
        input logic [15:0] word,
        input logic [15:0] pat,
        input int n
    );
        logic [31:0] p;
        logic [31:0] mask;
        logic [31:0] r;
        logic hit;
        hit = 1'b0;
        mask = (32'd1 << n) - 32'd1;
        p = {16'd0, pat} & mask;
        for (int i = 0; i < 16; i++) begin
            r = ((p << i) | (p >> (n - i))) & mask;
            if (i < n && r[15:0] == word)
                hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/lvds_rx_eye_picker.sv
// Circular longest-run search over the per-phase pass map, one index
// per cycle across two laps so wrap-around runs are measured whole.
module lvds_rx_eye_picker
    import lvds_rx_pkg::*;
#(
    parameter int PHASE_STEPS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PHASE_STEPS-1:0] pass_map,
    output logic [PSDA_W-1:0]      best,
    output logic [4:0]             len,
    output logic                   valid
);

    localparam int STEP_W = $clog2(2 * PHASE_STEPS);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(2 * PHASE_STEPS - 1);
    localparam logic [4:0] LEN_MAX = 5'(PHASE_STEPS);
    localparam logic [PSDA_W-1:0] PH_LAST = PSDA_W'(PHASE_STEPS - 1);

    logic              active;
    logic [PSDA_W-1:0] ph;
    logic [STEP_W-1:0] step;
    logic [4:0]        cur_len, cur_len_n;
    logic [PSDA_W-1:0] cur_start, cur_start_n;
    logic [4:0]        best_len, best_len_n;
    logic [PSDA_W-1:0] best_start, best_start_n;
    logic              hit, upd;
    logic [PSDA_W:0]   sum;

    // Strict '>' keeps the earliest-found run, giving lowest start on ties.
    always_comb begin
        hit = pass_map[ph];
        cur_len_n = 5'd0;
        if (hit)
            cur_len_n = (cur_len == LEN_MAX) ? cur_len : cur_len + 5'd1;
        cur_start_n = (hit && cur_len == 5'd0) ? ph : cur_start;
        upd = cur_len_n > best_len;
        best_len_n = upd ? cur_len_n : best_len;
        best_start_n = upd ? cur_start_n : best_start;
        sum = {1'b0, best_start_n} + ((best_len_n - 5'd1) >> 1);
        if (sum >= LEN_MAX)
            sum = sum - LEN_MAX;
    end

    assign valid = active && step == STEP_LAST;
    assign len = best_len_n;
    assign best = sum[PSDA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            ph <= '0;
            step <= '0;
            cur_len <= '0;
            cur_start <= '0;
            best_len <= '0;
            best_start <= '0;
        end else if (start) begin
            active <= 1'b1;
            ph <= '0;
            step <= '0;
            cur_len <= '0;
            cur_start <= '0;
            best_len <= '0;
            best_start <= '0;
        end else if (active) begin
            ph <= (ph == PH_LAST) ? '0 : ph + PSDA_W'(1);
            step <= step + STEP_W'(1);
            cur_len <= cur_len_n;
            cur_start <= cur_start_n;
            best_len <= best_len_n;
            best_start <= best_start_n;
            if (valid)
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/lvds_rx_phase_tuner.sv
// Sweeps rPLL psda, checks the training word and parks at the eye centre.
// Define LVDS_RX_TRACK_EN for continuous monitoring in DONE plus recal_pulse.
module lvds_rx_phase_tuner
    import lvds_rx_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               DES_W       = 7,
    parameter logic [DES_W-1:0] TRAIN_PAT   = 7'b1100011,
    parameter int               PHASE_STEPS = 16,
    parameter int               SETTLE_CYC  = 64,
    parameter int               SAMPLE_CYC  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pll_lock,
    input  logic [NUM_CH*DES_W-1:0] rx_data,
    output logic [PSDA_W-1:0]       psda,
    output logic [3:0]              dutyda,
    output logic [3:0]              fdly,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [4:0]              eye_width,
    output logic [PHASE_STEPS-1:0]  pass_map
`ifdef LVDS_RX_TRACK_EN
    ,
    output logic                    recal_pulse
`endif
);

    localparam int CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam logic [PSDA_W-1:0] PH_LAST = PSDA_W'(PHASE_STEPS - 1);

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_CH*DES_W-1:0] prev;
    logic                    err_now, err_acc;
    logic                    settle_last, samp_last;
    logic                    chk_en, abort, track_err, pick_start;
    logic [PSDA_W-1:0]       pk_best;
    logic [4:0]              pk_len;
    logic                    pk_valid;

    assign dutyda = DUTYDA_DEF;
    assign fdly = FDLY_DEF;
    assign settle_last = cnt == CNT_W'(SETTLE_CYC - 1);
    assign samp_last = cnt == CNT_W'(SAMPLE_CYC - 1);
    assign abort = !pll_lock &&
        (state == SETTLE || state == SAMPLE || state == EVAL || state == PICK);

`ifdef LVDS_RX_TRACK_EN
    assign chk_en = state == SAMPLE || state == DONE;
    assign track_err = state == DONE && samp_last && (err_acc || err_now);
`else
    assign chk_en = state == SAMPLE;
    assign track_err = 1'b0;
`endif

    // First word of each window is only checked against the rotations.
    always_comb begin
        err_now = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!is_rotation(16'(rx_data[c*DES_W +: DES_W]), 16'(TRAIN_PAT), DES_W))
                err_now = 1'b1;
            if (cnt != '0 && rx_data[c*DES_W +: DES_W] != prev[c*DES_W +: DES_W])
                err_now = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:
                if (start) state_n = WAIT_LOCK;
            WAIT_LOCK:
                if (pll_lock) state_n = SETTLE;
            SETTLE:
                if (!pll_lock) state_n = WAIT_LOCK;
                else if (settle_last) state_n = SAMPLE;
            SAMPLE:
                if (!pll_lock) state_n = WAIT_LOCK;
                else if (samp_last) state_n = EVAL;
            EVAL:
                if (!pll_lock) state_n = WAIT_LOCK;
                else if (psda == PH_LAST) state_n = PICK;
                else state_n = SETTLE;
            PICK:
                if (!pll_lock) state_n = WAIT_LOCK;
                else if (pk_valid) state_n = (pk_len != 5'd0) ? DONE : FAIL;
            DONE:
                if (!pll_lock || start || track_err) state_n = WAIT_LOCK;
            FAIL:
                if (!pll_lock || start) state_n = WAIT_LOCK;
            default:
                state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b1;
        done = 1'b0;
        fail = 1'b0;
        pick_start = 1'b0;
        unique case (state)
            IDLE: busy = 1'b0;
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            FAIL: begin
                busy = 1'b0;
                fail = 1'b1;
            end
            EVAL: pick_start = pll_lock && psda == PH_LAST;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psda <= '0;
            eye_width <= '0;
            pass_map <= '0;
            err_acc <= 1'b0;
            prev <= '0;
            cnt <= '0;
        end else begin
            prev <= rx_data;
            if (state != state_n || (state == DONE && samp_last))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (chk_en)
                err_acc <= ((cnt == '0) ? 1'b0 : err_acc) | err_now;
            else
                err_acc <= 1'b0;
            if (abort) begin
                psda <= '0;
                pass_map <= '0;
            end else if (state_n == WAIT_LOCK && state != WAIT_LOCK) begin
                psda <= '0;
            end else if (state == EVAL) begin
                pass_map[psda] <= !err_acc;
                if (psda != PH_LAST)
                    psda <= psda + PSDA_W'(1);
            end else if (state == PICK && pk_valid) begin
                psda <= (pk_len != 5'd0) ? pk_best : '0;
                eye_width <= pk_len;
            end
        end
    end

`ifdef LVDS_RX_TRACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            recal_pulse <= 1'b0;
        else
            recal_pulse <= track_err;
    end
`endif

    lvds_rx_eye_picker #(
        .PHASE_STEPS(PHASE_STEPS)
    ) u_picker (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (pick_start),
        .pass_map(pass_map),
        .best    (pk_best),
        .len     (pk_len),
        .valid   (pk_valid)
    );

endmodule

// File: tb/tb_lvds_rx_phase_tuner.sv
// Directed bench for lvds_rx_phase_tuner: rx_data is a function of psda
// and a per-test pass mask; results are checked against hand-derived values.
module tb_lvds_rx_phase_tuner;

    localparam int SWEEP = 16 * (64 + 256 + 1) + 2 * 16 + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pll_lock = 1'b1;
    logic [27:0] rx_data;
    logic [3:0]  psda, dutyda, fdly;
    logic        busy, done, fail;
    logic [4:0]  eye_width;
    logic [15:0] pass_map;
`ifdef LVDS_RX_TRACK_EN
    logic        recal_pulse;
`endif

    logic [15:0] pat_mask = 16'hFFFF;
    logic        bad_alt = 1'b0;
    logic        tog = 1'b0;
    logic        corrupt = 1'b0;
    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        tog = ~tog;
    end

    // Passing phases see steady rotations of 1100011 on every channel.
    always_comb begin
        rx_data = {7'b0001111, 7'b1110001, 7'b1100011, 7'b0111100};
        if (!pat_mask[psda]) begin
            if (bad_alt)
                rx_data[6:0] = tog ? 7'b1100011 : 7'b1000111;
            else
                rx_data[20:14] = 7'b1010101;
        end
        if (corrupt)
            rx_data[20:14] = 7'b1010101;
    end

    lvds_rx_phase_tuner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pll_lock   (pll_lock),
        .rx_data    (rx_data),
        .psda       (psda),
        .dutyda     (dutyda),
        .fdly       (fdly),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .eye_width  (eye_width),
        .pass_map   (pass_map)
`ifdef LVDS_RX_TRACK_EN
        ,
        .recal_pulse(recal_pulse)
`endif
    );

    task automatic run_sweep(input logic [15:0] m, input logic alt,
                             input int extra_at, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pat_mask = m;
        bad_alt = alt;
        cyc = 1;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL sweep_start: busy/done/fail=%b%b%b want 100", busy, done, fail);
        end
        while (!(done || fail) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_at);
        end
        start = 1'b0;
        vectors++;
        if (cyc >= 6000) begin
            errors++;
            $display("FAIL sweep_timeout: %0d cycles without done/fail", cyc);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (psda !== 4'd0) begin errors++; $display("FAIL reset_psda: got %0d want 0", psda); end
        vectors++;
        if (dutyda !== 4'b1000 || fdly !== 4'b0000) begin
            errors++; $display("FAIL reset_dutyda_fdly: got %b %b want 1000 0000", dutyda, fdly);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got %b%b%b want 000", busy, done, fail);
        end
        vectors++;
        if (eye_width !== 5'd0 || pass_map !== 16'h0) begin
            errors++; $display("FAIL reset_eye: got %0d %h want 0 0000", eye_width, pass_map);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc;
        run_sweep(16'h03E0, 1'b1, 0, cyc);
        vectors++;
        if (cyc != SWEEP) begin errors++; $display("FAIL basic_latency: got %0d want %0d", cyc, SWEEP); end
        vectors++;
        if (done !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL basic_done: got %b%b want 10", done, fail); end
        vectors++;
        if (psda !== 4'd7) begin errors++; $display("FAIL basic_psda: got %0d want 7", psda); end
        vectors++;
        if (eye_width !== 5'd5) begin errors++; $display("FAIL basic_width: got %0d want 5", eye_width); end
        vectors++;
        if (pass_map !== 16'h03E0) begin errors++; $display("FAIL basic_map: got %h want 03e0", pass_map); end
    endtask

    task automatic test_wrap;
        int cyc;
        run_sweep(16'hC003, 1'b0, 0, cyc);
        vectors++;
        if (psda !== 4'd15) begin errors++; $display("FAIL wrap_psda: got %0d want 15", psda); end
        vectors++;
        if (eye_width !== 5'd4) begin errors++; $display("FAIL wrap_width: got %0d want 4", eye_width); end
        vectors++;
        if (pass_map !== 16'hC003) begin errors++; $display("FAIL wrap_map: got %h want c003", pass_map); end
    endtask

    task automatic test_tie_start_ignored;
        int cyc;
        run_sweep(16'h0C0C, 1'b0, 100, cyc);
        vectors++;
        if (cyc != SWEEP) begin errors++; $display("FAIL ignore_start_latency: got %0d want %0d", cyc, SWEEP); end
        vectors++;
        if (psda !== 4'd2) begin errors++; $display("FAIL tie_psda: got %0d want 2", psda); end
        vectors++;
        if (eye_width !== 5'd2) begin errors++; $display("FAIL tie_width: got %0d want 2", eye_width); end
    endtask

    task automatic test_all_fail;
        int cyc;
        run_sweep(16'h0000, 1'b0, 0, cyc);
        vectors++;
        if (fail !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL allfail_flags: got fail=%b done=%b want 1 0", fail, done); end
        vectors++;
        if (psda !== 4'd0 || eye_width !== 5'd0) begin
            errors++; $display("FAIL allfail_psda: got %0d/%0d want 0/0", psda, eye_width);
        end
        vectors++;
        if (pass_map !== 16'h0) begin errors++; $display("FAIL allfail_map: got %h want 0000", pass_map); end
    endtask

    task automatic test_all_pass;
        int cyc;
        run_sweep(16'hFFFF, 1'b0, 0, cyc);
        vectors++;
        if (psda !== 4'd7) begin errors++; $display("FAIL allpass_psda: got %0d want 7", psda); end
        vectors++;
        if (eye_width !== 5'd16) begin errors++; $display("FAIL allpass_width: got %0d want 16", eye_width); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pat_mask = 16'h03E0;
        repeat (1000) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (psda !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_state: psda=%0d busy=%b done=%b want 0 0 0", psda, busy, done);
        end
        vectors++;
        if (pass_map !== 16'h0 || eye_width !== 5'd0) begin
            errors++; $display("FAIL midreset_eye: got %h/%0d want 0000/0", pass_map, eye_width);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_lock_drop;
        int c;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pat_mask = 16'h03E0;
        bad_alt = 1'b1;
        c = 0;
        while (psda != 4'd6 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (c >= 4000) begin errors++; $display("FAIL lockdrop_reach6: psda=%0d want 6", psda); end
        repeat (80) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        vectors++;
        if (psda !== 4'd0 || pass_map !== 16'h0) begin
            errors++; $display("FAIL lockdrop_abort: psda=%0d map=%h want 0 0000", psda, pass_map);
        end
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL lockdrop_busy: busy=%b done=%b want 1 0", busy, done);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || psda !== 4'd0) begin
            errors++; $display("FAIL lockdrop_wait: busy=%b psda=%0d want 1 0", busy, psda);
        end
        pll_lock = 1'b1;
        c = 0;
        while (!done && c < 6000) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (c != SWEEP - 1) begin errors++; $display("FAIL relock_latency: got %0d want %0d", c, SWEEP - 1); end
        vectors++;
        if (psda !== 4'd7 || pass_map !== 16'h03E0) begin
            errors++; $display("FAIL relock_result: psda=%0d map=%h want 7 03e0", psda, pass_map);
        end
    endtask

    task automatic test_lock_in_done;
        int c;
        pll_lock = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL donedrop_flags: done=%b busy=%b want 0 1", done, busy);
        end
        repeat (5) @(negedge clk);
        pll_lock = 1'b1;
        c = 0;
        while (!done && c < 6000) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (c != SWEEP - 1) begin errors++; $display("FAIL donedrop_recal: got %0d want %0d", c, SWEEP - 1); end
        vectors++;
        if (psda !== 4'd7 || eye_width !== 5'd5) begin
            errors++; $display("FAIL donedrop_result: psda=%0d width=%0d want 7 5", psda, eye_width);
        end
    endtask

`ifdef LVDS_RX_TRACK_EN
    task automatic test_track;
        int c;
        logic seen;
        repeat (300) @(negedge clk);
        vectors++;
        if (done !== 1'b1 || recal_pulse !== 1'b0) begin
            errors++; $display("FAIL track_idle: done=%b recal=%b want 1 0", done, recal_pulse);
        end
        corrupt = 1'b1;
        @(negedge clk);
        corrupt = 1'b0;
        c = 0;
        seen = 1'b0;
        while (!seen && c < 600) begin
            @(negedge clk);
            c++;
            if (recal_pulse === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin errors++; $display("FAIL track_pulse: recal_pulse=0 want 1"); end
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL track_restart: done=%b busy=%b want 0 1", done, busy);
        end
        pat_mask = 16'hC003;
        bad_alt = 1'b0;
        @(negedge clk);
        vectors++;
        if (recal_pulse !== 1'b0) begin errors++; $display("FAIL track_pulse_len: recal=%b want 0", recal_pulse); end
        c = 0;
        while (!done && c < 6000) begin
            @(negedge clk);
            c++;
        end
        vectors++;
        if (psda !== 4'd15 || eye_width !== 5'd4) begin
            errors++; $display("FAIL track_resweep: psda=%0d width=%0d want 15 4", psda, eye_width);
        end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_tie_start_ignored();
        test_all_fail();
        test_all_pass();
        test_reset_mid();
        test_lock_drop();
        test_lock_in_done();
`ifdef LVDS_RX_TRACK_EN
        test_track();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
